// File: rtl/sinc3_seq_ctrl.sv
// =============================================================================
// Module   : sinc3_seq_ctrl
// Purpose  : Sequencing controller for the sinc3 decimator: flush, settle-word
//            discard, decimation word strobe and valid/ready word delivery.
// Options  : SINC3_SEQ_CTRL_OVF_CNT_EN adds the saturating ovf_cnt[7:0] output.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module sinc3_seq_ctrl #(
    parameter int DECIM_LO     = 256,
    parameter int DECIM_HI     = 4096,
    parameter int SETTLE_WORDS = 3,
    parameter int FLUSH_CYC    = 2
) (
    input  logic        clk_adc,
    input  logic        rstn_adc,
    input  logic        enable,
    input  logic        cfg_req,
    input  logic [1:0]  cfg_mode,
    output logic        cfg_ack,
    output logic [1:0]  filt_mode,
    output logic        filt_rstn,
    output logic        word_stb,
    input  logic [15:0] filt_data,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf,
    input  logic        ovf_clr,
`ifdef SINC3_SEQ_CTRL_OVF_CNT_EN
    output logic [7:0]  ovf_cnt,
`endif
    output logic [1:0]  state
);

    localparam int c_DEC_MAX = (DECIM_HI > DECIM_LO) ? DECIM_HI : DECIM_LO;
    localparam int c_DEC_W   = $clog2(c_DEC_MAX);
    localparam int c_SET_W   = $clog2(SETTLE_WORDS + 1);
    localparam int c_FLS_W   = $clog2(FLUSH_CYC + 1);

    localparam logic [c_DEC_W-1:0] c_LAST_LO  = c_DEC_W'(DECIM_LO - 1);
    localparam logic [c_DEC_W-1:0] c_LAST_HI  = c_DEC_W'(DECIM_HI - 1);
    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_WORDS - 1);
    localparam logic [c_FLS_W-1:0] c_FLS_LAST = c_FLS_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FLUSH  = 2'b01,
        ST_SETTLE = 2'b10,
        ST_RUN    = 2'b11
    } state_t;

    state_t             r_state;
    logic [1:0]         r_filt_mode;
    logic               r_filt_rstn;
    logic               r_cfg_ack;
    logic               r_req_d;
    logic               r_word_stb;
    logic               r_cap_pend;
    logic [15:0]        r_out_data;
    logic               r_out_valid;
    logic               r_ovf;
    logic [c_DEC_W-1:0] r_dec_cnt;
    logic [c_SET_W-1:0] r_settle_cnt;
    logic [c_FLS_W-1:0] r_flush_cnt;

    logic               w_cfg_edge;
    logic [c_DEC_W-1:0] w_dec_last;
    logic [c_DEC_W-1:0] w_dec_nxt;

    assign w_cfg_edge = cfg_req & ~r_req_d;
    assign w_dec_last = r_filt_mode[1] ? c_LAST_HI : c_LAST_LO;
    assign w_dec_nxt  = (r_dec_cnt == w_dec_last) ? '0 : r_dec_cnt + 1'b1;

`ifdef SINC3_SEQ_CTRL_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;
    assign ovf_cnt = r_ovf_cnt;
`endif

    always_ff @(posedge clk_adc or negedge rstn_adc) begin
        if (!rstn_adc) begin
            r_state      <= ST_IDLE;
            r_filt_mode  <= 2'b00;
            r_filt_rstn  <= 1'b0;
            r_cfg_ack    <= 1'b0;
            r_req_d      <= 1'b0;
            r_word_stb   <= 1'b0;
            r_cap_pend   <= 1'b0;
            r_out_data   <= 16'h0000;
            r_out_valid  <= 1'b0;
            r_ovf        <= 1'b0;
            r_dec_cnt    <= '0;
            r_settle_cnt <= '0;
            r_flush_cnt  <= '0;
`ifdef SINC3_SEQ_CTRL_OVF_CNT_EN
            r_ovf_cnt    <= 8'h00;
`endif
        end else begin
            r_req_d    <= cfg_req;
            r_cfg_ack  <= w_cfg_edge;
            r_word_stb <= 1'b0;
            if (w_cfg_edge) begin
                r_filt_mode <= cfg_mode;
            end
            // Clear first; a drop later in this block overrides it.
            if (ovf_clr) begin
                r_ovf <= 1'b0;
`ifdef SINC3_SEQ_CTRL_OVF_CNT_EN
                r_ovf_cnt <= 8'h00;
`endif
            end

            if (r_state == ST_IDLE) begin
                r_filt_rstn <= 1'b0;
                r_dec_cnt   <= '0;
                r_cap_pend  <= 1'b0;
                if (enable && !w_cfg_edge) begin
                    r_state     <= ST_FLUSH;
                    r_flush_cnt <= '0;
                end
            end else if (!enable || w_cfg_edge) begin
                r_state     <= enable ? ST_FLUSH : ST_IDLE;
                r_flush_cnt <= '0;
                r_filt_rstn <= 1'b0;
                r_dec_cnt   <= '0;
                r_cap_pend  <= 1'b0;
                r_out_valid <= 1'b0;
            end else if (r_state == ST_FLUSH) begin
                r_dec_cnt <= '0;
                if (r_flush_cnt == c_FLS_LAST) begin
                    r_state      <= ST_SETTLE;
                    r_filt_rstn  <= 1'b1;
                    r_settle_cnt <= '0;
                end else begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                end
            end else begin
                // Strobe is registered one cycle ahead so it lines up with dec_cnt == D-1.
                r_dec_cnt  <= w_dec_nxt;
                r_word_stb <= (w_dec_nxt == w_dec_last);
                r_cap_pend <= r_word_stb;
                if (r_state == ST_SETTLE) begin
                    if (r_cap_pend) begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                        if (r_settle_cnt == c_SET_LAST) begin
                            r_state <= ST_RUN;
                        end
                    end
                end else if (r_cap_pend) begin
                    if (!r_out_valid || out_ready) begin
                        r_out_data  <= filt_data;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_ovf <= 1'b1;
`ifdef SINC3_SEQ_CTRL_OVF_CNT_EN
                        r_ovf_cnt <= (r_ovf_cnt == 8'hFF) ? 8'hFF : r_ovf_cnt + 1'b1;
`endif
                    end
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign state     = r_state;
    assign filt_mode = r_filt_mode;
    assign filt_rstn = r_filt_rstn;
    assign cfg_ack   = r_cfg_ack;
    assign word_stb  = r_word_stb;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_sinc3_seq_ctrl.sv
// =============================================================================
// Module   : tb_sinc3_seq_ctrl
// Purpose  : Directed bench for sinc3_seq_ctrl with a timeline-based reference
//            model compared every cycle, plus hand-computed anchor values.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_sinc3_seq_ctrl;

    localparam int DLO = 256;
    localparam int DHI = 4096;
    localparam int SW  = 3;
    localparam int FC  = 2;

    logic        clk_adc   = 1'b0;
    logic        rstn_adc  = 1'b1;
    logic        enable    = 1'b0;
    logic        cfg_req   = 1'b0;
    logic [1:0]  cfg_mode  = 2'b00;
    logic        cfg_ack;
    logic [1:0]  filt_mode;
    logic        filt_rstn;
    logic        word_stb;
    logic [15:0] filt_data = 16'h0000;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        ovf;
    logic        ovf_clr   = 1'b0;
    logic [1:0]  state;
`ifdef SINC3_SEQ_CTRL_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    int n_vec  = 0;
    int n_bad  = 0;
    int pe     = 0;
    bit cmp_on = 1'b0;

    sinc3_seq_ctrl dut (
        .clk_adc   (clk_adc),
        .rstn_adc  (rstn_adc),
        .enable    (enable),
        .cfg_req   (cfg_req),
        .cfg_mode  (cfg_mode),
        .cfg_ack   (cfg_ack),
        .filt_mode (filt_mode),
        .filt_rstn (filt_rstn),
        .word_stb  (word_stb),
        .filt_data (filt_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
`ifdef SINC3_SEQ_CTRL_OVF_CNT_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .state     (state)
    );

    always #5 clk_adc = ~clk_adc;

    // pe = number of rising edges since the last reset release.
    always @(posedge clk_adc or negedge rstn_adc) begin
        if (!rstn_adc) pe <= 0;
        else           pe <= pe + 1;
    end

    // Word sampled at edge k is 3*k + 0x1000.
    always @(negedge clk_adc) filt_data = 16'((pe + 1) * 3 + 4096);

    // Reference model: time since SETTLE entry decides strobes and captures.
    logic [1:0]  m_st    = 2'b00;
    logic [1:0]  m_mode  = 2'b00;
    logic        m_ack   = 1'b0;
    logic        m_stb   = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_ovf   = 1'b0;
    logic        m_req_d = 1'b0;
    logic [15:0] m_data  = 16'h0000;
    int          m_fage  = 0;
    int          m_t     = 0;
    int          m_cnt   = 0;

    always @(posedge clk_adc or negedge rstn_adc) begin
        if (!rstn_adc) begin
            m_st = 2'b00; m_mode = 2'b00; m_ack = 1'b0; m_stb = 1'b0;
            m_valid = 1'b0; m_ovf = 1'b0; m_req_d = 1'b0; m_data = 16'h0000;
            m_fage = 0; m_t = 0; m_cnt = 0;
        end else begin
            int d;
            int cnt_old;
            bit ce;
            d       = m_mode[1] ? DHI : DLO;
            cnt_old = m_cnt;
            ce      = cfg_req && !m_req_d;
            m_req_d = cfg_req;
            m_ack   = ce;
            if (ce) m_mode = cfg_mode;
            m_stb = 1'b0;
            if (ovf_clr) begin
                m_ovf = 1'b0;
                m_cnt = 0;
            end
            if (m_st == 2'b00) begin
                if (enable && !ce) begin
                    m_st = 2'b01;
                    m_fage = 0;
                end
            end else if (!enable || ce) begin
                m_st = enable ? 2'b01 : 2'b00;
                m_fage = 0;
                m_valid = 1'b0;
            end else if (m_st == 2'b01) begin
                m_fage = m_fage + 1;
                if (m_fage == FC) begin
                    m_st = 2'b10;
                    m_t = 0;
                end
            end else begin
                if (m_t >= d && (m_t % d) == 0 && (m_t / d) > SW) begin
                    if (!m_valid || out_ready) begin
                        m_data = filt_data;
                        m_valid = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                        m_cnt = (cnt_old >= 255) ? 255 : cnt_old + 1;
                    end
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end
                m_t = m_t + 1;
                m_st = (m_t > SW * d) ? 2'b11 : 2'b10;
                m_stb = ((m_t % d) == d - 1);
            end
        end
    end

    always @(negedge clk_adc) begin
        if (cmp_on) begin
            logic [24:0] a;
            logic [24:0] e;
            a = {state, filt_mode, cfg_ack, filt_rstn, word_stb, out_valid, ovf, out_data};
            e = {m_st, m_mode, m_ack, rstn_adc & (m_st[1]), m_stb, m_valid, m_ovf, m_data};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL model_cmp pe=%0d got %h expected %h (st,mode,ack,rstn,stb,vld,ovf,data)",
                         pe, a, e);
            end
`ifdef SINC3_SEQ_CTRL_OVF_CNT_EN
            n_vec++;
            if (ovf_cnt !== 8'(m_cnt)) begin
                n_bad++;
                $display("FAIL model_ovf_cnt pe=%0d got %0d expected %0d", pe, ovf_cnt, m_cnt);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_pe(input int k);
        while (pe < k) @(negedge clk_adc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          s1;
        int          s2;
        int          n_stb;
        int          last_stb;
        int          first_vld;
        int          acks;
        logic [15:0] first_dat;

        #1 rstn_adc = 1'b0;
        cmp_on = 1'b1;
        repeat (2) @(negedge clk_adc);
        chk("reset_state", state, 0);
        chk("reset_filt_rstn", filt_rstn, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_word_stb", word_stb, 0);

        // Mode 00, consumer always ready.
        out_ready = 1'b1;
        enable    = 1'b1;
        rstn_adc  = 1'b1;
        s1 = 0; n_stb = 0; last_stb = 0; first_vld = 0; first_dat = 16'h0000;
        while (pe < 1030) begin
            @(negedge clk_adc);
            if (pe == 2) begin
                chk("t1_flush_state", state, 1);
                chk("t1_flush_rstn_low", filt_rstn, 0);
            end
            if (pe == 3) chk("t1_settle_rstn_high", filt_rstn, 1);
            if (word_stb) begin
                if (s1 == 0) s1 = pe;
                n_stb++;
                last_stb = pe;
            end
            if (out_valid && first_vld == 0) begin
                first_vld = pe;
                first_dat = out_data;
            end
        end
        chk("t1_first_strobe", s1, 258);
        chk("t1_strobe_count", n_stb, 4);
        chk("t1_fourth_strobe", last_stb, 1026);
        chk("t1_first_valid", first_vld, 1028);
        chk("t1_first_data", first_dat, 16'h1C0C);
        chk("t1_run_state", state, 3);

        // Back-pressure across two strobes.
        out_ready = 1'b0;
        wait_pe(1541);
        chk("t3_held_valid", out_valid, 1);
        chk("t3_held_data", out_data, 16'h1F0C);
        chk("t3_ovf_set", ovf, 1);
`ifdef SINC3_SEQ_CTRL_OVF_CNT_EN
        chk("t3_ovf_cnt", ovf_cnt, 1);
`endif
        ovf_clr = 1'b1;
        wait_pe(1542);
        ovf_clr = 1'b0;
        chk("t3_ovf_cleared", ovf, 0);

        // Drop enable while a word is pending.
        enable = 1'b0;
        wait_pe(1543);
        chk("t4_state_idle", state, 0);
        chk("t4_valid_low", out_valid, 0);
        chk("t4_rstn_low", filt_rstn, 0);
        chk("t4_no_strobe", word_stb, 0);
        out_ready = 1'b1;
        wait_pe(1545);
        enable = 1'b1;

        // Mode change to 10 while running.
        wait_pe(2400);
        cfg_mode = 2'b10;
        cfg_req  = 1'b1;
        wait_pe(2401);
        chk("t2_ack_high", cfg_ack, 1);
        chk("t2_mode", filt_mode, 2);
        chk("t2_flush", state, 1);
        wait_pe(2402);
        chk("t2_ack_once", cfg_ack, 0);
        wait_pe(2403);
        chk("t2_settle", state, 2);
        s1 = 0; s2 = 0; n_stb = 0; first_vld = 0;
        while (pe < 18790) begin
            @(negedge clk_adc);
            if (pe == 2410) cfg_req = 1'b0;
            if (pe == 18700) out_ready = 1'b0;
            if (word_stb) begin
                n_stb++;
                if (n_stb == 1) s1 = pe;
                if (n_stb == 2) s2 = pe;
            end
            if (out_valid && first_vld == 0) begin
                first_vld = pe;
                first_dat = out_data;
            end
        end
        chk("t2_first_strobe", s1, 6498);
        chk("t2_second_strobe", s2, 10594);
        chk("t2_strobe_count", n_stb, 4);
        chk("t2_first_valid", first_vld, 18788);
        chk("t2_first_data", first_dat, 16'hEC2C);

        // Asynchronous reset between edges.
        chk("t5_pre_valid", out_valid, 1);
        chk("t5_pre_mode", filt_mode, 2);
        #2 rstn_adc = 1'b0;
        #1;
        chk("t5_state", state, 0);
        chk("t5_mode", filt_mode, 0);
        chk("t5_rstn", filt_rstn, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_ack", cfg_ack, 0);
        chk("t5_stb", word_stb, 0);
        chk("t5_ovf", ovf, 0);
        @(negedge clk_adc);
        enable = 1'b0;
        out_ready = 1'b1;
        @(negedge clk_adc);
        rstn_adc = 1'b1;
        wait_pe(3);
        chk("t5_stays_idle", state, 0);

        // Held cfg_req, then cfg edge coinciding with enable drop.
        enable = 1'b1;
        wait_pe(10);
        cfg_mode = 2'b01;
        cfg_req  = 1'b1;
        acks = 0;
        while (pe < 20) begin
            @(negedge clk_adc);
            if (cfg_ack) acks++;
        end
        chk("t6_single_ack", acks, 1);
        chk("t6_mode_01", filt_mode, 1);
        cfg_req = 1'b0;
        wait_pe(21);
        cfg_mode = 2'b10;
        cfg_req  = 1'b1;
        enable   = 1'b0;
        wait_pe(22);
        chk("t6_ack_edge", cfg_ack, 1);
        chk("t6_idle", state, 0);
        chk("t6_mode_10", filt_mode, 2);
        chk("t6_rstn_low", filt_rstn, 0);
        wait_pe(23);
        chk("t6_ack_drop", cfg_ack, 0);
        cfg_req = 1'b0;
        wait_pe(26);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
